// File: rtl/alu_resp_checker_pkg.sv
// ---------------------------------------------------------------------------
// alu_resp_checker_pkg
//   Shared definitions for the ALU response checker slice: opcode encodings,
//   flag bit positions and the checker run-state encoding. Imported by the
//   reference model and the checker top level.
// ---------------------------------------------------------------------------
package alu_resp_checker_pkg;

    // ALU opcodes as driven onto the oper bus of the ALU under test
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Bit positions inside the 4-bit flag vector
    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;

    // Run-state of the checker
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chkState_t;

endpackage

// File: rtl/alu_resp_checker_ref_model.sv
// ---------------------------------------------------------------------------
// alu_ref_model
//   Purely combinational golden model of the ALU. Given the operands and
//   opcode that were applied to the ALU it produces the result the ALU should
//   return and the matching flag vector.
// Ports
//   i_arg0   [DATA_WIDTH-1:0]  operand A
//   i_arg1   [DATA_WIDTH-1:0]  operand B
//   i_oper   [1:0]             opcode (ADD, SUB, AND, OR)
//   o_result [DATA_WIDTH-1:0]  predicted result, modulo 2^DATA_WIDTH
//   o_flag   [3:0]             predicted {OVF, POS, NEG, ERR}
// ---------------------------------------------------------------------------
import alu_resp_checker_pkg::*;

module alu_ref_model #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_arg0,
    input  logic [DATA_WIDTH-1:0] i_arg1,
    input  logic [1:0]            i_oper,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [3:0]            o_flag
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_overflow;

    // Arithmetic and logic datapath. Signed overflow only exists for ADD and
    // SUB: for ADD it happens when both operands share a sign that the result
    // does not; for SUB when the operands differ in sign and the result sign
    // departs from operand A.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (i_oper)
            OP_ADD: begin
                w_result   = i_arg0 + i_arg1;
                w_overflow = (i_arg0[MSB] == i_arg1[MSB]) && (w_result[MSB] != i_arg0[MSB]);
            end
            OP_SUB: begin
                w_result   = i_arg0 - i_arg1;
                w_overflow = (i_arg0[MSB] != i_arg1[MSB]) && (w_result[MSB] != i_arg0[MSB]);
            end
            OP_AND: w_result = i_arg0 & i_arg1;
            OP_OR:  w_result = i_arg0 | i_arg1;
            default: begin
                w_result   = '0;
                w_overflow = 1'b0;
            end
        endcase
    end

    // Flag vector assembly. ERR is never raised by a healthy ALU.
    always_comb begin
        o_result               = w_result;
        o_flag                 = '0;
        o_flag[FLAG_ERR]       = 1'b0;
        o_flag[FLAG_NEG]       = w_result[MSB];
        o_flag[FLAG_POS]       = (w_result != '0) && !w_result[MSB];
        o_flag[FLAG_OVERFLOW]  = w_overflow;
    end

endmodule

// File: rtl/alu_resp_checker.sv
// ---------------------------------------------------------------------------
// alu_resp_checker
//   Response-side checker for the ALU. Every stimulus applied to the ALU while
//   a run is active is fed through the reference model; the prediction rides a
//   LATENCY-deep pipeline and is compared against the ALU output when it
//   reaches the tail. Counts compares and mismatches (saturating) and captures
//   the first failing compare of each run.
// Ports
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_en                run enable; 0->1 starts a run, 1->0 ends it
//   i_valid             stimulus on i_arg0/i_arg1/i_oper applied this cycle
//   i_arg0, i_arg1      operands applied to the ALU
//   i_oper              opcode applied to the ALU
//   i_result, i_flag    ALU response
//   o_mismatch          one-cycle pulse the cycle after a failed compare
//   o_chk_cnt           number of compares in this run
//   o_err_cnt           number of failed compares in this run
//   o_first_idx         compare index of the first failure
//   o_first_exp         {expected result, expected flag} at first failure
//   o_first_act         {actual result, actual flag} at first failure
//   o_done              run finished and pipeline drained
//   o_pass              run finished with no failures
// ---------------------------------------------------------------------------
import alu_resp_checker_pkg::*;

module alu_resp_checker #(
    parameter int DATA_WIDTH = 4,
    parameter int LATENCY    = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_arg0,
    input  logic [DATA_WIDTH-1:0]   i_arg1,
    input  logic [1:0]              i_oper,
    input  logic [DATA_WIDTH-1:0]   i_result,
    input  logic [3:0]              i_flag,
    output logic                    o_mismatch,
    output logic [CNT_WIDTH-1:0]    o_chk_cnt,
    output logic [CNT_WIDTH-1:0]    o_err_cnt,
    output logic [CNT_WIDTH-1:0]    o_first_idx,
    output logic [DATA_WIDTH+3:0]   o_first_exp,
    output logic [DATA_WIDTH+3:0]   o_first_act,
    output logic                    o_done,
    output logic                    o_pass
);

    localparam int TAIL    = LATENCY - 1;
    localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);

    logic [DATA_WIDTH-1:0] w_expResult;
    logic [3:0]            w_expFlag;
    logic [DATA_WIDTH+3:0] w_tailExp;
    logic [DATA_WIDTH+3:0] w_tailAct;
    logic                  w_isMatch;
    logic                  w_cmpDo;
    logic                  w_cmpFail;
    logic [CNT_WIDTH-1:0]  w_errNext;

    logic                  r_pipeValid  [LATENCY];
    logic [DATA_WIDTH-1:0] r_pipeResult [LATENCY];
    logic [3:0]            r_pipeFlag   [LATENCY];

    chkState_t             r_state;
    logic [DRAIN_W-1:0]    r_drainCnt;
    logic                  r_mismatch;
    logic [CNT_WIDTH-1:0]  r_chkCnt;
    logic [CNT_WIDTH-1:0]  r_errCnt;
    logic [CNT_WIDTH-1:0]  r_firstIdx;
    logic [DATA_WIDTH+3:0] r_firstExp;
    logic [DATA_WIDTH+3:0] r_firstAct;
    logic                  r_done;
    logic                  r_pass;

    alu_ref_model #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_refModel (
        .i_arg0   (i_arg0),
        .i_arg1   (i_arg1),
        .i_oper   (i_oper),
        .o_result (w_expResult),
        .o_flag   (w_expFlag)
    );

    // Prediction pipeline. A new entry is only accepted while a run is
    // active; draining and idle cycles push empty slots in behind it so
    // in-flight predictions keep moving toward the tail.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_pipeValid[k]  <= 1'b0;
                r_pipeResult[k] <= '0;
                r_pipeFlag[k]   <= '0;
            end
        end else begin
            r_pipeValid[0]  <= i_valid && (r_state == ST_RUN);
            r_pipeResult[0] <= w_expResult;
            r_pipeFlag[0]   <= w_expFlag;
            for (int k = 1; k < LATENCY; k++) begin
                r_pipeValid[k]  <= r_pipeValid[k-1];
                r_pipeResult[k] <= r_pipeResult[k-1];
                r_pipeFlag[k]   <= r_pipeFlag[k-1];
            end
        end
    end

    // Tail compare. The match flag defaults low and is only raised when the
    // equality test is definitely true, so any X or Z on the ALU response
    // ends up counted as a mismatch.
    always_comb begin
        w_tailExp = {r_pipeResult[TAIL], r_pipeFlag[TAIL]};
        w_tailAct = {i_result, i_flag};
        w_isMatch = 1'b0;
        if (w_tailAct == w_tailExp) begin
            w_isMatch = 1'b1;
        end
        w_cmpDo   = r_pipeValid[TAIL];
        w_cmpFail = r_pipeValid[TAIL] && !w_isMatch;
        w_errNext = r_errCnt;
        if (w_cmpFail && (r_errCnt != '1)) begin
            w_errNext = r_errCnt + 1'b1;
        end
    end

    // Run control, counters and first-failure capture. Counter and capture
    // updates come first; the state case afterwards may clear them when a new
    // run starts, which only happens while the pipeline is empty. The pass
    // verdict uses the post-update error count so a failure in the last drain
    // cycle is not missed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_drainCnt <= '0;
            r_mismatch <= 1'b0;
            r_chkCnt   <= '0;
            r_errCnt   <= '0;
            r_firstIdx <= '0;
            r_firstExp <= '0;
            r_firstAct <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_mismatch <= w_cmpFail;
            if (w_cmpDo && (r_chkCnt != '1)) begin
                r_chkCnt <= r_chkCnt + 1'b1;
            end
            r_errCnt <= w_errNext;
            if (w_cmpFail && (r_errCnt == '0)) begin
                r_firstIdx <= r_chkCnt;
                r_firstExp <= w_tailExp;
                r_firstAct <= w_tailAct;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_en) begin
                        r_state    <= ST_RUN;
                        r_chkCnt   <= '0;
                        r_errCnt   <= '0;
                        r_firstIdx <= '0;
                        r_firstExp <= '0;
                        r_firstAct <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!i_en) begin
                        r_state    <= ST_DRAIN;
                        r_drainCnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_errNext == '0);
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mismatch  = r_mismatch;
    assign o_chk_cnt   = r_chkCnt;
    assign o_err_cnt   = r_errCnt;
    assign o_first_idx = r_firstIdx;
    assign o_first_exp = r_firstExp;
    assign o_first_act = r_firstAct;
    assign o_done      = r_done;
    assign o_pass      = r_pass;

endmodule
